if_id_skid: RTL and testbench
=============================

IF_ID_SKID -- requirements
Module: if_id_skid

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the instruction word width.
REQ-002 Parameter BUS_WIDTH, default 32, SHALL set the PC width.
REQ-003 Parameter NOP_INST, default 32'h00000013, SHALL set the bubble instruction driven when the stage is empty.
REQ-004 Parameter SKID_EN, default 1, SHALL select the mode: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-007 in_valid  input  1  SHALL mark the fetch-side beat as valid.
REQ-008 in_ready  output  1  SHALL indicate the stage accepts a beat this cycle.
REQ-009 instruction_i  input  DATA_WIDTH  SHALL carry the fetched instruction.
REQ-010 pc_in  input  BUS_WIDTH  SHALL carry the PC of instruction_i.
REQ-011 out_valid  output  1  SHALL mark instruction_o/pc_out as a valid decode beat.
REQ-012 out_ready  input  1  SHALL indicate decode consumes the beat.
REQ-013 instruction_o  output  DATA_WIDTH  SHALL be the registered instruction to decode.
REQ-014 pc_out  output  BUS_WIDTH  SHALL be the registered PC to decode.
REQ-015 hold  input  1  SHALL be the hazard-unit stall; while high, no beat is consumed.
REQ-016 flush  input  1  SHALL discard all held and incoming beats.
REQ-017 count  output  2  SHALL report occupancy: 0, 1 or 2.

Function
REQ-018 in_fire SHALL be in_valid & in_ready; consume SHALL be out_valid & out_ready & ~hold.
REQ-019 The FSM SHALL have states EMPTY (count 0), BUSY (count 1, main entry valid) and FULL (count 2, main and skid entries valid).
REQ-020 EMPTY: in_fire SHALL go to BUSY and load main from the inputs; otherwise stay EMPTY.
REQ-021 BUSY: in_fire & consume SHALL stay BUSY and load main from the inputs; in_fire & ~consume SHALL go to FULL and load skid; ~in_fire & consume SHALL go to EMPTY; otherwise stay BUSY with outputs unchanged.
REQ-022 FULL: consume SHALL go to BUSY and move skid into main; otherwise stay FULL with all entries unchanged.
REQ-023 With SKID_EN=1, in_ready SHALL be a registered signal equal to (state != FULL), with no combinational path from out_ready or hold.
REQ-024 With SKID_EN=0, FULL SHALL be unreachable and in_ready SHALL be (state == EMPTY) | consume.
REQ-025 out_valid SHALL be 1 exactly in BUSY and FULL; instruction_o/pc_out SHALL always reflect the main entry.
REQ-026 On entering EMPTY, instruction_o SHALL be NOP_INST and pc_out SHALL keep its last value.
REQ-027 Latency SHALL be one cycle: a beat accepted at edge N is on instruction_o/pc_out after edge N with out_valid=1.
REQ-028 Beats SHALL leave in acceptance order, with no loss or duplication absent flush.
REQ-029 flush SHALL have priority over hold, in_fire and consume: next state EMPTY, skid invalidated, instruction_o <= NOP_INST, pc_out unchanged, and any same-cycle in_fire beat dropped.
REQ-030 hold SHALL behave exactly as out_ready=0 and SHALL NOT block acceptance while state != FULL.
REQ-031 Output registers SHALL change only on EMPTY->BUSY, a consume or a flush.

Reset
REQ-032 rst SHALL take priority over flush and all other inputs.
REQ-033 rst SHALL force state EMPTY, out_valid 0, instruction_o NOP_INST, pc_out 0, count 0, skid invalid, and in_ready 1 on the following cycle.
REQ-034 rst asserted mid-operation, including in FULL, SHALL discard all entries without emitting a beat.

Verification
REQ-035 Streaming: out_ready=1 and beats (0x00000093,pc 0x0), (0x00100113,pc 0x4) on consecutive cycles -> each appears one cycle later; in_ready stays 1; count stays 1.
REQ-036 Backpressure: out_ready=0 and beats A then B -> count reaches 2 and in_ready=0; out_ready=1 -> A then B emitted in order; count falls 2->1->0.
REQ-037 Hold: hold=1 for 3 cycles in BUSY with out_ready=1 -> outputs frozen and out_valid=1; hold=0 -> beat consumed on the next edge.
REQ-038 Flush in FULL with in_valid=1 -> next cycle: out_valid=0, instruction_o=0x00000013, pc_out unchanged, count=0, incoming beat never emitted.
REQ-039 Reset in FULL with flush=1 -> pc_out=0, instruction_o=0x00000013, in_ready=1 after one cycle.
REQ-040 SKID_EN=0: out_ready toggling randomly with continuous in_valid -> count never exceeds 1; in_ready equals (state==EMPTY)|consume every cycle; order preserved.

Source files
------------

// File: rtl/if_id_skid.sv
// ---------------------------------------------------------------------------
// if_id_skid -- IF/ID pipeline register with optional two-entry skid buffer.
//
// Sits between instruction fetch and decode. Holds up to two fetched beats
// (main + skid) so fetch can be stalled from a registered ready, breaking the
// combinational path from decode backpressure to fetch.
//
// Handshake: a beat transfers on a rising edge when valid and ready are both
// high in the preceding cycle. On the input side in_fire = in_valid & in_ready.
// On the output side consume = out_valid & out_ready & ~hold. Valid never
// depends on ready. Payload is stable while valid is high and unconsumed.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   in_valid/ready  fetch-side handshake
//   instruction_i   fetched instruction, pc_in its PC
//   out_valid/ready decode-side handshake
//   instruction_o   registered instruction (NOP_INST when empty)
//   pc_out          registered PC (holds last value when empty)
//   hold            hazard stall, acts as out_ready=0
//   flush           discards all held and incoming beats
//   count           occupancy 0/1/2; encodes the FSM state directly
// ---------------------------------------------------------------------------
module if_id_skid #(
    parameter int unsigned             DATA_WIDTH = 32,
    parameter int unsigned             BUS_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0]   NOP_INST   = 32'h00000013,
    parameter bit                      SKID_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] instruction_i,
    input  logic [BUS_WIDTH-1:0]  pc_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] instruction_o,
    output logic [BUS_WIDTH-1:0]  pc_out,
    input  logic                  hold,
    input  logic                  flush,
    output logic [1:0]            count
);

    // State encoding equals occupancy so count is the state itself.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic [BUS_WIDTH-1:0]  pc_q, pc_d;
    logic [DATA_WIDTH-1:0] skid_inst_q, skid_inst_d;
    logic [BUS_WIDTH-1:0]  skid_pc_q, skid_pc_d;
    logic                  in_ready_q, in_ready_d;
    logic                  in_fire;
    logic                  consume;

    assign out_valid     = (state_q != EMPTY);
    assign consume       = out_valid & out_ready & ~hold;
    // Skid mode uses the registered ready (no path from out_ready/hold);
    // single-entry mode accepts when empty or when the held beat leaves.
    assign in_ready      = SKID_EN ? in_ready_q : ((state_q == EMPTY) | consume);
    assign in_fire       = in_valid & in_ready;
    assign instruction_o = inst_q;
    assign pc_out        = pc_q;
    assign count         = state_q;

    always_comb begin
        state_d     = state_q;
        inst_d      = inst_q;
        pc_d        = pc_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        if (flush) begin
            // Flush wins over everything but reset; pc_out keeps its value.
            state_d = EMPTY;
            inst_d  = NOP_INST;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = BUSY;
                        inst_d  = instruction_i;
                        pc_d    = pc_in;
                    end
                end
                BUSY: begin
                    if (in_fire && consume) begin
                        inst_d = instruction_i;
                        pc_d   = pc_in;
                    end else if (in_fire) begin
                        // Main is stalled: park the new beat in the skid slot.
                        state_d     = FULL;
                        skid_inst_d = instruction_i;
                        skid_pc_d   = pc_in;
                    end else if (consume) begin
                        state_d = EMPTY;
                        inst_d  = NOP_INST;
                    end
                end
                FULL: begin
                    if (consume) begin
                        state_d = BUSY;
                        inst_d  = skid_inst_q;
                        pc_d    = skid_pc_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    inst_d  = NOP_INST;
                end
            endcase
        end
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            inst_q      <= NOP_INST;
            pc_q        <= '0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            inst_q      <= inst_d;
            pc_q        <= pc_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
            in_ready_q  <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_if_id_skid.sv
// ---------------------------------------------------------------------------
// tb_if_id_skid -- directed + random bench for if_id_skid.
// Two instances share the stimulus: dut1 (SKID_EN=1) and dut0 (SKID_EN=0).
// 'sel' chooses which instance is checked against the occupancy model.
// ---------------------------------------------------------------------------
module tb_if_id_skid;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] instruction_i;
    logic [31:0] pc_in;
    logic        out_ready;
    logic        hold;
    logic        flush;

    logic        rdy1, ov1, rdy0, ov0;
    logic [31:0] io1, po1, io0, po0;
    logic [1:0]  cnt1, cnt0;

    logic        sel;
    int          vectors;
    int          miscompares;
    logic [63:0] exp_q[$];
    logic        m_rdy;
    logic [31:0] m_pc;
    logic [31:0] next_pc;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    if_id_skid #(.SKID_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .instruction_i(instruction_i), .pc_in(pc_in), .out_valid(ov1),
        .out_ready(out_ready), .instruction_o(io1), .pc_out(po1),
        .hold(hold), .flush(flush), .count(cnt1)
    );

    if_id_skid #(.SKID_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .instruction_i(instruction_i), .pc_in(pc_in), .out_valid(ov0),
        .out_ready(out_ready), .instruction_o(io0), .pc_out(po0),
        .hold(hold), .flush(flush), .count(cnt0)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check at negedge against the model, update the model from
    // the driven inputs, then return at posedge+1 for the next drive.
    task automatic cycle();
        logic       cons, exp_rdy, fire;
        logic       o_rdy, o_ov;
        logic [1:0] o_cnt;
        logic [31:0] o_io, o_po;
        @(negedge clk);
        o_rdy = sel ? rdy1 : rdy0;
        o_ov  = sel ? ov1  : ov0;
        o_cnt = sel ? cnt1 : cnt0;
        o_io  = sel ? io1  : io0;
        o_po  = sel ? po1  : po0;
        cons    = (exp_q.size() != 0) && out_ready && !hold;
        exp_rdy = sel ? m_rdy : ((exp_q.size() == 0) || cons);
        check("in_ready", {63'd0, o_rdy}, {63'd0, exp_rdy});
        check("out_valid", {63'd0, o_ov}, {63'd0, (exp_q.size() != 0)});
        check("count", {62'd0, o_cnt}, 64'(exp_q.size()));
        if (exp_q.size() != 0) begin
            check("instruction_o", {32'd0, o_io}, {32'd0, exp_q[0][31:0]});
            check("pc_out", {32'd0, o_po}, {32'd0, exp_q[0][63:32]});
        end else begin
            check("instruction_o_nop", {32'd0, o_io}, {32'd0, NOP});
            check("pc_out_held", {32'd0, o_po}, {32'd0, m_pc});
        end
        if (!sel) check("count_le1", {63'd0, (o_cnt <= 2'd1)}, 64'd1);
        fire = in_valid && exp_rdy;
        if (rst) begin
            exp_q.delete();
            m_rdy = 1'b1;
            m_pc  = '0;
        end else if (flush) begin
            exp_q.delete();
            m_rdy = 1'b1;
        end else begin
            if (cons) void'(exp_q.pop_front());
            if (fire) exp_q.push_back({pc_in, instruction_i});
            m_rdy = (exp_q.size() != 2);
        end
        if (exp_q.size() != 0) m_pc = exp_q[0][63:32];
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic iv, input logic orr, input logic hd, input logic fl);
        in_valid  = iv;
        out_ready = orr;
        hold      = hd;
        flush     = fl;
    endtask

    task automatic beat(input logic [31:0] inst, input logic [31:0] pc);
        in_valid      = 1'b1;
        instruction_i = inst;
        pc_in         = pc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_rdy = 1'b1;
        m_pc  = '0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        vectors       = 0;
        miscompares   = 0;
        sel           = 1'b1;
        rst           = 1'b1;
        instruction_i = '0;
        pc_in         = '0;
        next_pc       = 32'h100;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();

        // reset state
        cycle();

        // streaming
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        beat(32'h00000093, 32'h0); cycle();
        beat(32'h00100113, 32'h4); cycle();
        in_valid = 1'b0; cycle(); cycle();

        // backpressure: fill to two, then drain in order
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        beat(32'hAAAA0001, 32'h8);  cycle();
        beat(32'hBBBB0002, 32'hC);  cycle();
        in_valid = 1'b0; cycle(); cycle();
        out_ready = 1'b1; cycle(); cycle(); cycle();

        // hold for three cycles in BUSY with out_ready high
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        beat(32'hCCCC0003, 32'h10); cycle();
        in_valid = 1'b0; hold = 1'b1;
        cycle(); cycle(); cycle();
        hold = 1'b0; cycle(); cycle();

        // flush in FULL with an incoming beat
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        beat(32'hDDDD0004, 32'h14); cycle();
        beat(32'hEEEE0005, 32'h18); cycle();
        beat(32'hFFFF0006, 32'h1C); flush = 1'b1; cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0); cycle(); cycle();

        // reset in FULL with flush high
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        beat(32'h12340007, 32'h20); cycle();
        beat(32'h12340008, 32'h24); cycle();
        in_valid = 1'b0; flush = 1'b1; rst = 1'b1; cycle();
        rst = 1'b0; flush = 1'b0; cycle(); cycle();

        // random traffic, skid mode
        for (int i = 0; i < 200; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0));
            instruction_i = $urandom;
            pc_in         = next_pc;
            next_pc       = next_pc + 32'd4;
            cycle();
        end

        // single-entry mode: continuous in_valid, random out_ready
        sel = 1'b0;
        do_reset();
        for (int i = 0; i < 150; i++) begin
            drive(1'b1, $urandom_range(0, 1), 1'b0, 1'b0);
            instruction_i = $urandom;
            pc_in         = next_pc;
            next_pc       = next_pc + 32'd4;
            cycle();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(); cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
